breath_ctrl: RTL and testbench
==============================

# breath_ctrl

Sequencing controller for the breathing-LED engine. It generates the brightness envelope: ramp up, hold high, ramp down, hold low. The envelope drives a PWM comparator, and after each full breath the controller hands the PWM output to the next enabled LED channel in round-robin order. It sits between the board-level enable/channel-mask registers and the LED pins, one instance per LED bank, in the same clock domain as `breath_led`.

## Interface
- `CH`, 4: number of LED channels.
- `DUTY_W`, 8: duty and PWM counter width; PWM period = 2^DUTY_W clocks.
- `STEP`, 16: duty increment/decrement per PWM period; must satisfy 1 ≤ STEP < 2^DUTY_W.
- `HOLD_PERIODS`, 2: PWM periods spent in each hold state; must be ≥ 1.

- `clk`  in  1  system clock, all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `en`  in  1  run enable; synchronous.
- `ch_en`  in  CH  per-channel participation mask.
- `led`  out  CH  PWM outputs; only the selected channel toggles, all others are 0.
- `duty`  out  DUTY_W  current envelope value.
- `ch_sel`  out  log2(CH)  index of the active channel.
- `state`  out  3  FSM state encoding: IDLE=0, RAMP_UP=1, HOLD_HI=2, RAMP_DN=3, HOLD_LO=4.
- `cycle_done`  out  1  one-clock pulse at the end of each full breath.

## Operation
- Reset (`rst`=0) forces the following values immediately: state=IDLE, duty=0, pwm_cnt=0, hold_cnt=0, ch_sel=0, led=0, cycle_done=0.
- `pwm_cnt`:
  - Increments every clock and wraps from 2^DUTY_W−1 to 0 when state≠IDLE.
  - Held at 0 in IDLE.
  - `tick` = (pwm_cnt == 2^DUTY_W−1) and state≠IDLE.
- `led` is registered each clock: led[ch_sel] ← (pwm_cnt < duty); all other bits ← 0.
  - duty=0 gives a constant 0.
  - duty=2^DUTY_W−1 is low for exactly one clock per period.
- FSM transitions:
  - IDLE: if en=1 and ch_en≠0, set ch_sel to the lowest-index set bit of ch_en, duty=0, then go to RAMP_UP.
  - RAMP_UP, on tick:
    - If duty+STEP ≥ 2^DUTY_W−1: duty←2^DUTY_W−1, hold_cnt←0, go to HOLD_HI.
    - Else duty←duty+STEP.
    - The sum is computed at DUTY_W+1 bits, so there is no wrap.
  - HOLD_HI, on tick: if hold_cnt==HOLD_PERIODS−1, go to RAMP_DN; else hold_cnt++.
  - RAMP_DN, on tick:
    - If duty ≤ STEP: duty←0, hold_cnt←0, go to HOLD_LO.
    - Else duty←duty−STEP.
  - HOLD_LO, on tick with hold_cnt==HOLD_PERIODS−1:
    - Pulse cycle_done.
    - Select the next set bit of ch_en, searching from ch_sel+1 upward and wrapping modulo CH. The current channel itself is eligible last.
    - If one is found, go to RAMP_UP with duty=0. If ch_en==0, go to IDLE.
- A ch_en change mid-breath does not abort the active channel. The mask is sampled only in IDLE and at the end of HOLD_LO.
- en=0 in any state: on the next edge, state←IDLE, duty←0, pwm_cnt←0, led←0. ch_sel keeps its value. A cycle_done pulse is suppressed if it coincides with en=0.
- Simultaneous tick and en=0: en=0 wins.

## Timing
- IDLE→RAMP_UP takes one clock after en=1 is sampled. The first tick follows 2^DUTY_W clocks later.
- `led` lags (pwm_cnt, duty) by one clock.
- The duty update is visible on the clock after the tick.
- Breath length with defaults:
  - RAMP_UP: 16 ticks (15 steps to 240, then saturate to 255).
  - HOLD_HI: 2 ticks.
  - RAMP_DN: 16 ticks (255→15, then 0).
  - HOLD_LO: 2 ticks.
  - Total 36 periods = 9216 clocks.
- cycle_done is asserted in the same clock that state re-enters RAMP_UP or IDLE.

## Test plan
- Reset/idle: hold rst low for 1 clock mid-period at time 2, en=0 → all outputs 0, state=0; pwm_cnt frozen at 0 for 100 clocks.
- Single channel, defaults: ch_en=4'b0001, en=1 →
  - duty sequence 0,16,…,240,255 (held 2 periods), 239,…,15,0.
  - cycle_done pulses exactly once, 9216 clocks after start.
  - led[3:1] stay 0 throughout.
- PWM fidelity: at duty=16, led[0] is high for exactly 16 of every 256 clocks. At duty=255, led[0] is low for exactly 1 of every 256 clocks.
- Round robin: ch_en=4'b1010 → ch_sel visits 1,3,1,3 across four cycle_done pulses. Clearing ch_en[3] during channel 3's RAMP_DN lets that breath finish, then ch_sel=1.
- Abort: drop en during HOLD_HI → next clock state=IDLE, duty=0, led=0, no cycle_done. Re-raise en → restart on the lowest enabled channel from duty=0.
- Empty mask: ch_en→0 during HOLD_LO of the final tick → cycle_done pulses, state=IDLE, led=0 thereafter.

Source files
------------

// File: rtl/breath_ctrl.sv
// Breathing-LED envelope sequencer: ramp/hold envelope into a PWM
// comparator, handed round-robin to the enabled LED channels.
module breath_ctrl #(
    parameter int CH           = 4,
    parameter int DUTY_W       = 8,
    parameter int STEP         = 16,
    parameter int HOLD_PERIODS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [CH-1:0]         ch_en,
    output logic [CH-1:0]         led,
    output logic [DUTY_W-1:0]     duty,
    output logic [$clog2(CH)-1:0] ch_sel,
    output logic [2:0]            state,
    output logic                  cycle_done
);

    localparam int SW = $clog2(CH);
    localparam int HW = $clog2(HOLD_PERIODS + 1);
    localparam logic [DUTY_W-1:0] DMAX = {DUTY_W{1'b1}};
    localparam logic [DUTY_W:0]   STEP_W = (DUTY_W+1)'(STEP);
    localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_PERIODS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RAMP_UP = 3'd1,
        HOLD_HI = 3'd2,
        RAMP_DN = 3'd3,
        HOLD_LO = 3'd4
    } st_t;

    st_t             st;
    logic [DUTY_W-1:0] pwm_cnt;
    logic [HW-1:0]   hold_cnt;
    logic            tick;
    logic [DUTY_W:0] up_sum;
    logic [CH-1:0]   led_nxt;
    logic [SW-1:0]   lo_ch;
    logic [SW-1:0]   rr_ch;
    logic [SW-1:0]   rr_k;
    logic            rr_hit;

    assign state   = st;
    assign tick    = (pwm_cnt == DMAX) && (st != IDLE);
    assign up_sum  = {1'b0, duty} + STEP_W;
    assign led_nxt = CH'(pwm_cnt < duty) << ch_sel;

    always_comb begin
        lo_ch = '0;
        for (int i = CH - 1; i >= 0; i--) begin
            if (ch_en[i]) lo_ch = SW'(i);
        end
    end

    // Walk from ch_sel+1 round to ch_sel; nearer candidates overwrite farther.
    always_comb begin
        rr_ch  = ch_sel;
        rr_hit = 1'b0;
        rr_k   = '0;
        for (int i = CH; i >= 1; i--) begin
            rr_k = SW'((int'(ch_sel) + i) % CH);
            if (ch_en[rr_k]) begin
                rr_ch  = rr_k;
                rr_hit = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st         <= IDLE;
            duty       <= '0;
            pwm_cnt    <= '0;
            hold_cnt   <= '0;
            ch_sel     <= '0;
            led        <= '0;
            cycle_done <= 1'b0;
        end else if (!en) begin
            st         <= IDLE;
            duty       <= '0;
            pwm_cnt    <= '0;
            hold_cnt   <= '0;
            led        <= '0;
            cycle_done <= 1'b0;
        end else begin
            cycle_done <= 1'b0;
            led        <= led_nxt;
            pwm_cnt    <= (st == IDLE) ? '0 : pwm_cnt + 1'b1;
            unique case (st)
                IDLE: begin
                    if (|ch_en) begin
                        ch_sel <= lo_ch;
                        duty   <= '0;
                        st     <= RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    if (tick) begin
                        if (up_sum >= {1'b0, DMAX}) begin
                            duty     <= DMAX;
                            hold_cnt <= '0;
                            st       <= HOLD_HI;
                        end else begin
                            duty <= up_sum[DUTY_W-1:0];
                        end
                    end
                end
                HOLD_HI: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST) st <= RAMP_DN;
                        else hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                RAMP_DN: begin
                    if (tick) begin
                        if ({1'b0, duty} <= STEP_W) begin
                            duty     <= '0;
                            hold_cnt <= '0;
                            st       <= HOLD_LO;
                        end else begin
                            duty <= duty - STEP_W[DUTY_W-1:0];
                        end
                    end
                end
                HOLD_LO: begin
                    if (tick) begin
                        if (hold_cnt == HOLD_LAST) begin
                            cycle_done <= 1'b1;
                            duty       <= '0;
                            if (rr_hit) begin
                                ch_sel <= rr_ch;
                                st     <= RAMP_UP;
                            end else begin
                                st <= IDLE;
                            end
                        end else begin
                            hold_cnt <= hold_cnt + 1'b1;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_breath_ctrl.sv
// Directed bench for breath_ctrl: envelope, PWM, round robin, abort.
module tb_breath_ctrl;

    logic       clk;
    logic       rst;
    logic       en;
    logic [3:0] ch_en;
    logic [3:0] led;
    logic [7:0] duty;
    logic [1:0] ch_sel;
    logic [2:0] state;
    logic       cycle_done;

    int checks = 0;
    int errors = 0;

    breath_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ch_en      (ch_en),
        .led        (led),
        .duty       (duty),
        .ch_sel     (ch_sel),
        .state      (state),
        .cycle_done (cycle_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int lim, output int n);
        n = 0;
        while (cycle_done !== 1'b1 && n < lim) begin
            step(1);
            n++;
        end
    endtask

    // Duty after k ticks of a breath with default parameters.
    function automatic int exp_duty(input int k);
        if (k <= 15) return 16 * k;
        if (k <= 18) return 255;
        if (k <= 33) return 255 - 16 * (k - 18);
        return 0;
    endfunction

    function automatic int exp_state(input int k);
        if (k <= 15) return 1;
        if (k <= 17) return 2;
        if (k <= 33) return 3;
        if (k <= 35) return 4;
        return 1;
    endfunction

    initial begin
        int hi;
        int bad_hi;
        int pulses;
        int n;

        rst   = 1'b1;
        en    = 1'b0;
        ch_en = 4'b0000;

        // Reset asserted mid-period at time 2
        #2 rst = 1'b0;
        #1;
        chk("rst_state", 32'(state), 0);
        chk("rst_duty", 32'(duty), 0);
        chk("rst_led", 32'(led), 0);
        chk("rst_chsel", 32'(ch_sel), 0);
        chk("rst_done", 32'(cycle_done), 0);
        #9 rst = 1'b1;
        step(100);
        chk("idle_pwm", 32'(dut.pwm_cnt), 0);
        chk("idle_state", 32'(state), 0);
        chk("idle_led", 32'(led), 0);

        // Single channel breath, one period per iteration
        ch_en = 4'b0001;
        en    = 1'b1;
        step(1);
        chk("start_state", 32'(state), 1);
        chk("start_duty", 32'(duty), 0);
        chk("start_chsel", 32'(ch_sel), 0);
        bad_hi = 0;
        pulses = 0;
        for (int k = 1; k <= 36; k++) begin
            hi = 0;
            for (int c = 0; c < 256; c++) begin
                if (c > 0) step(1);
                else step(256 - 255);
                if (led[0] === 1'b1) hi++;
                if (led[3:1] !== 3'b000) bad_hi++;
                if (cycle_done === 1'b1) pulses++;
                if (k < 36 || c < 255) begin
                    if (cycle_done === 1'b1 && !(k == 36 && c == 255))
                        bad_hi += 1000;
                end
            end
            chk($sformatf("duty k=%0d", k), 32'(duty), 32'(exp_duty(k)));
            chk($sformatf("state k=%0d", k), 32'(state),
                32'(exp_state(k)));
            chk($sformatf("pwm_hi k=%0d", k), 32'(hi),
                32'(exp_duty(k - 1)));
        end
        chk("breath_done", 32'(cycle_done), 1);
        chk("done_count", 32'(pulses), 1);
        chk("led_others", 32'(bad_hi), 0);
        chk("wrap_chsel", 32'(ch_sel), 0);

        // Round robin over channels 1 and 3
        en = 1'b0;
        step(1);
        chk("stop_state", 32'(state), 0);
        chk("stop_duty", 32'(duty), 0);
        ch_en = 4'b1010;
        en    = 1'b1;
        step(1);
        chk("rr_start_sel", 32'(ch_sel), 1);
        wait_done(10000, n);
        chk("rr1_len", 32'(n), 9216);
        chk("rr1_sel", 32'(ch_sel), 3);
        chk("rr1_state", 32'(state), 1);
        step(1);
        wait_done(10000, n);
        chk("rr2_len", 32'(n), 9215);
        chk("rr2_sel", 32'(ch_sel), 1);
        step(1);
        wait_done(10000, n);
        chk("rr3_len", 32'(n), 9215);
        chk("rr3_sel", 32'(ch_sel), 3);

        // Drop channel 3 from the mask while it ramps down
        step(1);
        step(256 * 20);
        chk("rr4_mid_state", 32'(state), 3);
        chk("rr4_mid_sel", 32'(ch_sel), 3);
        ch_en = 4'b0010;
        wait_done(10000, n);
        chk("rr4_len", 32'(n), 4095);
        chk("rr4_sel", 32'(ch_sel), 1);
        chk("rr4_state", 32'(state), 1);

        // Abort during HOLD_HI
        step(1);
        step(4096 + 100);
        chk("ab_pre_state", 32'(state), 2);
        chk("ab_pre_duty", 32'(duty), 255);
        en = 1'b0;
        step(1);
        chk("ab_state", 32'(state), 0);
        chk("ab_duty", 32'(duty), 0);
        chk("ab_led", 32'(led), 0);
        chk("ab_done", 32'(cycle_done), 0);
        chk("ab_sel", 32'(ch_sel), 1);
        step(10);
        chk("ab_idle_done", 32'(cycle_done), 0);
        ch_en = 4'b1100;
        en    = 1'b1;
        step(1);
        chk("re_state", 32'(state), 1);
        chk("re_sel", 32'(ch_sel), 2);
        chk("re_duty", 32'(duty), 0);

        // Empty the mask inside the final HOLD_LO period
        step(9010);
        chk("em_state", 32'(state), 4);
        ch_en = 4'b0000;
        wait_done(1000, n);
        chk("em_len", 32'(n), 206);
        chk("em_done", 32'(cycle_done), 1);
        chk("em_state_idle", 32'(state), 0);
        chk("em_led", 32'(led), 0);
        step(1);
        chk("em_done_drop", 32'(cycle_done), 0);
        step(300);
        chk("em_late_led", 32'(led), 0);
        chk("em_late_state", 32'(state), 0);
        chk("em_late_pwm", 32'(dut.pwm_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
